// File: rtl/dff_arb_pkg.sv
// Shared types, defaults and helpers for the round-robin register-bank arbiter.
package dff_arb_pkg;

    localparam int unsigned NreqDefault     = 4;
    localparam int unsigned WidthDefault    = 8;
    localparam int unsigned MaxBurstDefault = 8;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_GRANT
    } arb_state_e;

    // Index width that never collapses to zero bits (NREQ=1 or 2 still needs one bit).
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dff_rr_pick.sv
// Rotating-priority search: first set request bit starting at ptr_i, wrapping modulo NREQ.
module dff_rr_pick
    import dff_arb_pkg::*;
#(
    parameter int unsigned NREQ = NreqDefault
) (
    input  logic [NREQ-1:0]               req_i,
    input  logic [clog2_min1(NREQ)-1:0]   ptr_i,
    output logic                          found_o,
    output logic [clog2_min1(NREQ)-1:0]   idx_o
);

    localparam int unsigned IW = clog2_min1(NREQ);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest requester (offset 0 = ptr) wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            cand = IW'((32'(ptr_i) + 32'(k)) % NREQ);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/dff_rr_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// Optional burst lock mode is enabled by defining DFF_ARB_LOCK_EN; the default build
// performs exactly one write (or abort) per grant.
module dff_rr_arbiter
    import dff_arb_pkg::*;
#(
    parameter int unsigned NREQ      = NreqDefault,
    parameter int unsigned WIDTH     = WidthDefault,
    parameter int unsigned MAX_BURST = MaxBurstDefault
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NREQ-1:0]               req_i,
    input  logic [NREQ*WIDTH-1:0]         wdata_i,
`ifdef DFF_ARB_LOCK_EN
    input  logic [NREQ-1:0]               lock_i,
`endif
    output logic [NREQ-1:0]               gnt_o,
    output logic [clog2_min1(NREQ)-1:0]   owner_o,
    output logic [WIDTH-1:0]              q_o,
    output logic                          q_valid_o,
    output logic                          wr_done_o
);

    localparam int unsigned OW = clog2_min1(NREQ);

    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("dff_rr_arbiter: NREQ must be in 2..16");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("dff_rr_arbiter: MAX_BURST must be >= 1");
    end

    arb_state_e        state_q, state_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              q_valid_q, q_valid_d;
    logic              wr_done_q, wr_done_d;

    logic              pick_found;
    logic [OW-1:0]     pick_idx;
    logic              owner_req;
    logic              stay_grant;
    logic [OW-1:0]     ptr_next;
    logic [WIDTH-1:0]  wdata_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign wdata_arr[i] = wdata_i[i*WIDTH +: WIDTH];
    end

    dff_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign owner_req = req_i[owner_q];
    // Owner gets lowest priority next round, even after an abort.
    assign ptr_next  = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef DFF_ARB_LOCK_EN
    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] burst_q, burst_d;
    logic [CW-1:0] burst_inc;

    assign burst_inc  = burst_q + 1'b1;
    assign stay_grant = lock_i[owner_q] & owner_req & (32'(burst_inc) < MAX_BURST);
`else
    assign stay_grant = 1'b0;
`endif

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> GRANT on any request, GRANT -> IDLE unless a burst is held.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (pick_found) state_d = ST_GRANT;
            ST_GRANT: if (!stay_grant) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values for grant, pointer, owner, shared register and burst counter.
    always_comb begin
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        wr_done_d = 1'b0;
`ifdef DFF_ARB_LOCK_EN
        burst_d   = burst_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (pick_found) begin
                    gnt_d[pick_idx] = 1'b1;
                    owner_d         = pick_idx;
`ifdef DFF_ARB_LOCK_EN
                    burst_d         = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (owner_req) begin
                    q_d       = wdata_arr[owner_q];
                    q_valid_d = 1'b1;
                    wr_done_d = 1'b1;
`ifdef DFF_ARB_LOCK_EN
                    burst_d   = burst_inc;
`endif
                end
                if (!stay_grant) begin
                    gnt_d = '0;
                    ptr_d = ptr_next;
                end
            end
            default: gnt_d = '0;
        endcase
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            wr_done_q <= 1'b0;
`ifdef DFF_ARB_LOCK_EN
            burst_q   <= '0;
`endif
        end else begin
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            wr_done_q <= wr_done_d;
`ifdef DFF_ARB_LOCK_EN
            burst_q   <= burst_d;
`endif
        end
    end

    // All outputs come straight from registers.
    assign gnt_o     = gnt_q;
    assign owner_o   = owner_q;
    assign q_o       = q_q;
    assign q_valid_o = q_valid_q;
    assign wr_done_o = wr_done_q;

endmodule

// File: doc/dff_rr_arbiter.md
# dff_rr_arbiter

Round-robin arbiter and write sequencer that shares one WIDTH-bit register bank among NREQ requesters. A granted requester writes its data word into the shared register. It sits in front of the D-flip-flop datapath models and replaces direct multi-driver access to a common register. Fairness comes from a rotating priority pointer. An optional lock mode allows bounded multi-cycle bursts.

## Interface
- NREQ, 4, number of requesters (2..16)
- WIDTH, 8, register and data width
- MAX_BURST, 8, maximum consecutive writes per grant (lock mode only, >=1)
- clk  in  1  rising-edge clock
- rstn  in  1  reset, synchronous, active-low
- req  in  NREQ  request per requester, level, held until served
- wdata  in  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- lock  in  NREQ  burst hold request per requester (present only with DFF_ARB_LOCK_EN)
- gnt  out  NREQ  registered one-hot grant, all-zero when idle
- owner  out  max(1,$clog2(NREQ))  index of current/last grantee
- q  out  WIDTH  shared register contents
- q_valid  out  1  sticky; 1 once any write has occurred since reset
- wr_done  out  1  one-cycle pulse, registered, for each write to q

## Operation
- Reset (rstn=0 at a rising edge) forces: state=IDLE, gnt=0, owner=0, q=0, q_valid=0, wr_done=0, ptr=0, burst count=0.
- States: IDLE and GRANT.
- IDLE:
  - If req!=0, pick the first set req bit scanning ptr, ptr+1, ... (mod NREQ).
  - Next edge: gnt=onehot(i), owner=i, state=GRANT, burst count=0.
  - If req=0: stay in IDLE; gnt=0, wr_done=0.
- GRANT, on each edge:
  - If req[owner]=1: q<=wdata[owner], q_valid<=1, wr_done<=1, burst count+1.
  - If req[owner]=0: abort. No write, wr_done=0.
  - Exit conditions are listed below.
- Exit GRANT, without lock mode: always after one cycle.
  - gnt<=0, ptr<=(owner+1) mod NREQ, state=IDLE.
- Exit GRANT, with lock mode: stay in GRANT while all of the following hold; otherwise exit as above.
  - lock[owner]=1
  - req[owner]=1
  - burst count (after increment) < MAX_BURST
- The pointer always advances past the owner on exit, including on abort. The granted requester therefore has lowest priority next round.
- gnt never has more than one bit set. owner holds its value in IDLE.
- req/lock bits of non-owners are ignored while in GRANT.
- wdata is sampled only at the write edge. No buffering; the requester holds wdata valid while gnt[i]=1.

## Timing
- Request to grant: 1 cycle (req seen in IDLE at edge n gives gnt at n+1).
- Grant to write: q and wr_done update at edge n+2.
- Single-write throughput: one write per 2 cycles.
- Lock-mode burst: one write per cycle, up to MAX_BURST, then a mandatory IDLE cycle.
- Back-to-back requesters: gap of exactly 1 IDLE cycle between grants.
- Reset asserted mid-GRANT takes effect at that edge: no write, gnt=0, q=0.

## Configuration
- DFF_ARB_LOCK_EN defined:
  - lock port exists.
  - Burst counter (width $clog2(MAX_BURST+1)) is implemented.
  - GRANT may persist as described above.
- DFF_ARB_LOCK_EN undefined:
  - lock port and burst counter are absent.
  - MAX_BURST is ignored.
  - Every grant performs at most one write.

## Structure
- Package dff_arb_pkg holds:
  - state enum (ST_IDLE, ST_GRANT)
  - function clog2_min1
  - default parameter constants
- Sub-module dff_rr_pick (combinational):
  - inputs req, ptr
  - outputs found, idx
  - rotate-priority search used by the IDLE state
- Top module holds state, ptr, gnt, owner, q, q_valid, wr_done and the burst counter.

## Test plan
- Reset: drive rstn=0 for 2 cycles with req=4'b1111 -> gnt=0, q=0, q_valid=0, wr_done=0. After release, first gnt=4'b0001 one cycle later.
- Round-robin: req=4'b1111 held, wdata words 0x11/0x22/0x33/0x44 -> grants 0,1,2,3,0 every 2 cycles; q sequence 0x11,0x22,0x33,0x44,0x11; one wr_done per write.
- Abort: req=4'b0100 gives gnt=4'b0100; drop req[2] in the grant cycle -> no wr_done, q unchanged, ptr=3. Next req=4'b1111 grants requester 3.
- Lock burst (DFF_ARB_LOCK_EN, MAX_BURST=8): req[1]=lock[1]=1 held with req[0]=1 -> 8 consecutive writes from requester 1, 1 IDLE cycle, then gnt=4'b0001.
- No lock (macro undefined): same stimulus without lock -> requester 1 writes once, then requester 0 is granted.
- Mid-operation reset: rstn=0 on the write edge of a grant -> q=0, q_valid=0, wr_done=0, gnt=0; the write is lost.
